// File: rtl/image_bank_arbiter.sv
// Arbiter/sequencer granting the shared four-bank image RAM port to the loader (writes) and conv engine (reads).
// Optional macro IMG_ARB_RR_EN: round-robin under contention instead of fixed write-over-read priority.
module image_bank_arbiter #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_rvalid,
  output logic [31:0]   rd_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wren,
  input  logic [31:0]   ram_q,
  output logic          busy
);

  localparam int unsigned VW = RD_LAT + 1;

  logic          prio_wr;
  logic [VW-1:0] vld;

`ifdef IMG_ARB_RR_EN
  // Pointer flips only on contended grants, so lone requesters never disturb the W,R alternation.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_wr <= 1'b1;
    end else if (wr_valid && rd_valid) begin
      prio_wr <= ~prio_wr;
    end
  end
`else
  assign prio_wr = 1'b1;
`endif

  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    if (!reset) begin
      wr_ready = wr_valid && (!rd_valid || prio_wr);
      rd_ready = rd_valid && (!wr_valid || !prio_wr);
    end
  end

  // Bank-side registers plus the read-valid pipeline that tracks RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= '0;
      vld       <= '0;
      rd_rvalid <= 1'b0;
      rd_rdata  <= '0;
    end else begin
      ram_wren <= '0;
      if (wr_ready) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
        ram_wren  <= wr_be;
      end else if (rd_ready) begin
        ram_addr <= rd_addr;
      end
      vld       <= {vld[VW-2:0], rd_ready};
      rd_rvalid <= vld[RD_LAT];
      if (vld[RD_LAT]) begin
        rd_rdata <= ram_q;
      end
    end
  end

  assign busy = |vld;

endmodule

// File: tb/tb_image_bank_arbiter.sv
// Scoreboard bench for image_bank_arbiter; four instances (RD_LAT 1..4) share one stimulus stream.
module tb_image_bank_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned NI = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    int          due;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wren;
    logic        is_wr;
  } ram_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  logic          wr_ready_g [NI];
  logic          rd_ready_g [NI];
  logic          rd_rvalid_g[NI];
  logic          busy_g     [NI];
  logic [31:0]   rd_rdata_g [NI];
  logic [31:0]   ram_q_g    [NI];
  logic [31:0]   ram_wdata_g[NI];
  logic [AW-1:0] ram_addr_g [NI];
  logic [3:0]    ram_wren_g [NI];

  rd_exp_t     rq[NI][$];
  ram_exp_t    wq[$];
  logic [31:0] shadow [0:(1<<AW)-1];
  int          cyc;
  int          checks;
  int          errors;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned L = g + 1;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] qd [L];

    assign ram_q_g[g] = qd[L-1];

    image_bank_arbiter #(.RD_LAT(L), .AW(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready_g[g]),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready_g[g]),
      .rd_addr  (rd_addr),
      .rd_rvalid(rd_rvalid_g[g]),
      .rd_rdata (rd_rdata_g[g]),
      .ram_addr (ram_addr_g[g]),
      .ram_wdata(ram_wdata_g[g]),
      .ram_wren (ram_wren_g[g]),
      .ram_q    (ram_q_g[g]),
      .busy     (busy_g[g])
    );

    // Pipelined RAM: array read at the first edge after the address, read-before-write.
    initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = init_word(a);
      forever begin
        @(posedge clk);
        qd[0] <= mem[ram_addr_g[g]];
        for (int i = 1; i < int'(L); i++) qd[i] <= qd[i-1];
        for (int b = 0; b < 4; b++)
          if (ram_wren_g[g][b]) mem[ram_addr_g[g]][8*b +: 8] <= ram_wdata_g[g][8*b +: 8];
      end
    end

    always @(negedge clk) begin
      rd_exp_t e;
      logic    eb;
      if (rd_rvalid_g[g]) begin
        if (rq[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected L%0d cyc %0d: got 1 expected 0", L, cyc);
        end else begin
          e = rq[g].pop_front();
          check($sformatf("rd_cycle_L%0d", L), 32'(cyc), 32'(e.due));
          check($sformatf("rd_data_L%0d", L), rd_rdata_g[g], e.data);
        end
      end else if (rq[g].size() != 0 && rq[g][0].due <= cyc) begin
        e = rq[g].pop_front();
        checks++;
        errors++;
        $display("FAIL rvalid_missing L%0d cyc %0d: got 0 expected 1 (data %h)", L, cyc, e.data);
      end
      eb = 1'b0;
      for (int i = 0; i < rq[g].size(); i++)
        if (cyc >= rq[g][i].due - int'(L) - 1 && cyc < rq[g][i].due) eb = 1'b1;
      check($sformatf("busy_L%0d", L), 32'(busy_g[g]), 32'(eb));
    end
  end

  // Bank-side port checks on the RD_LAT=1 instance.
  always @(negedge clk) begin
    ram_exp_t r;
    if (wq.size() != 0 && wq[0].due < cyc) begin
      r = wq.pop_front();
      checks++;
      errors++;
      $display("FAIL ram_stale cyc %0d: got none expected addr %h at cyc %0d", cyc, r.addr, r.due);
    end
    if (wq.size() != 0 && wq[0].due == cyc) begin
      r = wq.pop_front();
      check("ram_addr", 32'(ram_addr_g[0]), 32'(r.addr));
      check("ram_wren", 32'(ram_wren_g[0]), 32'(r.wren));
      if (r.is_wr) check("ram_wdata", ram_wdata_g[0], r.wdata);
    end else begin
      check("ram_idle_wren", 32'(ram_wren_g[0]), 32'h0);
    end
  end

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic rv, input logic [AW-1:0] ra,
                       output logic wg, output logic rg);
    ram_exp_t r;
    rd_exp_t  e;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_valid = rv; rd_addr = ra;
    @(negedge clk);
    wg = wr_ready_g[0];
    rg = rd_ready_g[0];
    check("one_grant", 32'(wg && rg), 32'h0);
    if (wg) begin
      r.due = cyc + 1; r.addr = wa; r.wdata = wd; r.wren = be; r.is_wr = 1'b1;
      wq.push_back(r);
      for (int b = 0; b < 4; b++) if (be[b]) shadow[wa][8*b +: 8] = wd[8*b +: 8];
    end
    if (rg) begin
      r.due = cyc + 1; r.addr = ra; r.wdata = '0; r.wren = '0; r.is_wr = 1'b0;
      wq.push_back(r);
      for (int g = 0; g < int'(NI); g++) begin
        e.due = cyc + g + 3;
        e.data = shadow[ra];
        rq[g].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_addr"},  32'(ram_addr_g[0]), 32'h0);
    check({tag, "_ram_wdata"}, ram_wdata_g[0], 32'h0);
    check({tag, "_ram_wren"},  32'(ram_wren_g[0]), 32'h0);
    check({tag, "_rvalid"},    32'(rd_rvalid_g[0]), 32'h0);
    check({tag, "_rdata"},     rd_rdata_g[0], 32'h0);
    check({tag, "_busy"},      32'(busy_g[0]), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       wg, rg;
    logic [5:0] gseq, gexp;
    int         wi, ri;
    for (int a = 0; a < (1 << AW); a++) shadow[a] = init_word(a);
    reset = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b1; rd_valid = 1'b1;
    @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready_g[0]), 32'h0);
    check("rst_rd_ready", 32'(rd_ready_g[0]), 32'h0);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    reset = 1'b0;

    drive(1'b1, 14'h0123, 32'hDDCC_BBAA, 4'hF, 1'b0, '0, wg, rg);
    check("wr_full_ready", 32'(wg), 32'h1);
    drive(1'b1, 14'h0123, 32'h1122_3344, 4'b0101, 1'b0, '0, wg, rg);
    check("wr_part_ready", 32'(wg), 32'h1);
    drive(1'b1, 14'h0200, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, wg, rg);
    check("wr_be0_ready", 32'(wg), 32'h1);
    drive(1'b0, '0, '0, '0, 1'b0, '0, wg, rg);

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(10 + i), wg, rg);
      check("b2b_rd_ready", 32'(rg), 32'h1);
    end
    // Read-then-write to the same address: the read keeps the pre-write data.
    drive(1'b0, '0, '0, '0, 1'b1, 14'h0123, wg, rg);
    drive(1'b1, 14'h0123, 32'h9999_9999, 4'hF, 1'b0, '0, wg, rg);
    drive(1'b0, '0, '0, '0, 1'b1, 14'h0123, wg, rg);
    drive(1'b0, '0, '0, '0, 1'b1, 14'h0200, wg, rg);
    repeat (3) drive(1'b0, '0, '0, '0, 1'b0, '0, wg, rg);

    wi = 0; ri = 0; gseq = '0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, AW'(14'h0300 + wi), 32'hA000_0000 + 32'(wi), 4'hF,
            1'b1, AW'(14'h0300 + ri), wg, rg);
      check("contend_one", 32'(wg ^ rg), 32'h1);
      gseq[5-k] = wg;
      if (wg) wi++;
      if (rg) ri++;
    end
`ifdef IMG_ARB_RR_EN
    gexp = 6'b101010;
`else
    gexp = 6'b111111;
`endif
    check("contend_seq", 32'(gseq), 32'(gexp));
    if (!rg) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(14'h0300 + ri), wg, rg);
      check("drain_rd_ready", 32'(rg), 32'h1);
    end
    repeat (8) drive(1'b0, '0, '0, '0, 1'b0, '0, wg, rg);

    // Reset one cycle after a read accept drops that read everywhere.
    drive(1'b0, '0, '0, '0, 1'b1, 14'h0050, wg, rg);
    check("pre_rst_rd_ready", 32'(rg), 32'h1);
    rd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < int'(NI); g++) rq[g].delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) drive(1'b0, '0, '0, '0, 1'b0, '0, wg, rg);
    drive(1'b0, '0, '0, '0, 1'b1, 14'h0123, wg, rg);
    check("post_rst_rd_ready", 32'(rg), 32'h1);
    repeat (8) drive(1'b0, '0, '0, '0, 1'b0, '0, wg, rg);

    for (int g = 0; g < int'(NI); g++) check("rq_empty", 32'(rq[g].size()), 32'h0);
    check("wq_empty", 32'(wq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_bank_arbiter.md
# image_bank_arbiter

Arbiter and sequencer for the four byte-wide image RAM banks, which share one 14-bit address. It gives the single bank port to two requesters: the image loader (HPS write path) and the convolution engine (4-byte window reads). Each requester uses a valid/ready handshake. The block registers every RAM-side signal and returns read data with a fixed, parameterised latency.

## Interface
- RD_LAT, default 1: RAM read latency in cycles, from registered address to valid `ram_q`; legal range 1–4.
- AW, default 14: bank address width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  loader write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  32  byte i goes to bank i (bits 8i+7:8i).
- wr_be  in  4  per-bank write enable.
- rd_valid  in  1  conv read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  AW  read address.
- rd_rvalid  out  1  read data valid, one pulse per accepted read.
- rd_rdata  out  32  {bank3,bank2,bank1,bank0} bytes.
- ram_addr  out  AW  shared bank address (registered).
- ram_wdata  out  32  bank write bytes (registered).
- ram_wren  out  4  per-bank write enable (registered).
- ram_q  in  32  concatenated bank read data.
- busy  out  1  high while any accepted read is still in flight.

## Operation
- A transfer occurs on a cycle where valid && ready. At most one requester is granted per cycle.
- `wr_ready`/`rd_ready` are combinational from the valids and the priority state. Both are 0 while `reset` is high.
- Default priority, with `IMG_ARB_RR_EN` undefined:
  - If both requesters are valid, the write wins and `rd_ready` = 0.
  - A lone requester is granted immediately.
- Write grant: on the next edge, `ram_addr`←`wr_addr`, `ram_wdata`←`wr_data`, `ram_wren`←`wr_be`.
- `wr_be` = 0 is still a handshake, but `ram_wren` = 0 for that cycle.
- Read grant: on the next edge, `ram_addr`←`rd_addr` and `ram_wren`←0. A 1 is pushed into an (RD_LAT+1)-deep valid shift register.
- `rd_rdata` is `ram_q` registered on the cycle the shift register's tap RD_LAT is 1. `rd_rvalid` pulses together with it.
- With no grant, `ram_wren`←0, and `ram_addr`/`ram_wdata` hold their last values.
- Reads are fully pipelined: back-to-back reads return back-to-back data in order. There is no backpressure on `rd_rvalid`; the consumer must always accept.
- A write granted the cycle after a read to the same address does not affect that read's data, because the read address was already registered.
- `busy` = OR of the valid shift register.
- Reset mid-read: the shift register clears, so in-flight reads are dropped. `rd_rvalid` is 0 starting the cycle after reset is sampled.

## Timing
- Reset values: `ram_addr`=0, `ram_wdata`=0, `ram_wren`=0, `rd_rvalid`=0, `rd_rdata`=0, `busy`=0. The priority pointer resets to favour write.
- Write latency: a handshake at edge N drives `ram_wren` high during cycle N+1.
- Read latency: a handshake at edge N puts `ram_addr` out during cycle N+1. `rd_rvalid`/`rd_rdata` appear during cycle N+RD_LAT+2, which is 3 cycles for RD_LAT=1.
- Sustained throughput is one transfer per cycle, either type.
- Requester rules:
  - Once `*_valid` is raised, it and its address/data stay stable until ready.
  - The arbiter may switch grant between cycles only when the losing side was not yet accepted.

## Configuration
- `IMG_ARB_RR_EN`, undefined: fixed write-over-read priority. A continuous writer starves reads.
- `IMG_ARB_RR_EN`, defined:
  - A 1-bit pointer toggles to the other requester after each grant made while both were valid.
  - Under contention, grants alternate W,R,W,R starting with W after reset.
  - A lone requester is still granted immediately; its grant does not toggle the pointer.

## Test plan
- Reset, then a single write: addr=0x0123, data=0xDDCCBBAA, be=4'b1111. Required: `wr_ready` the same cycle; next cycle `ram_addr`=0x0123, `ram_wren`=4'hF, `ram_wdata`=0xDDCCBBAA.
- Partial write: be=4'b0101. Required: `ram_wren`=4'b0101; a be=0 write handshakes with `ram_wren`=0.
- Four back-to-back reads, addr 10–13, with RD_LAT=1 and a RAM model. Required: `rd_rvalid` high for 4 consecutive cycles starting 3 cycles after the first accept, data in order; `busy` high throughout.
- Both valid for 6 cycles:
  - Without the macro: 6 write grants and `rd_ready`=0 throughout.
  - With `IMG_ARB_RR_EN`: grants W,R,W,R,W,R.
- Reset asserted 1 cycle after a read accept. Required: no `rd_rvalid` pulse follows, and all outputs are at reset values the next cycle.
- Sweep RD_LAT=1..4. Required: read accept to `rd_rvalid` is exactly RD_LAT+2 cycles each time.
